// File: rtl/embedded_io_ctrl.sv
// Isolation/direction sequencer for a bank of embedded I/O cells.
// Each direction change runs isolate -> apply -> settle -> release, so the SoC never sees drivers glitch.
module embedded_io_ctrl #(
  parameter int NUM_IO    = 8,
  parameter int ISO_SETUP = 4,
  parameter int SETTLE    = 8,
  parameter int CNT_W     = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FABRIC_READY,
  input  logic              FORCE_ISOLATE,
  input  logic              CFG_VALID,
  input  logic [NUM_IO-1:0] CFG_DIR,
  output logic              CFG_READY,
  output logic              CFG_DONE,
  output logic              IO_ISOL_N,
  output logic [NUM_IO-1:0] DIR_MASK,
  output logic              BUSY,
  output logic [1:0]        DBG_STATE
);

  localparam logic [1:0] ST_WAIT_FABRIC = 2'd0;
  localparam logic [1:0] ST_SETTLE      = 2'd1;
  localparam logic [1:0] ST_ACTIVE      = 2'd2;
  localparam logic [1:0] ST_ISO_ENTER   = 2'd3;

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] ISO_LD    = CNT_W'(ISO_SETUP - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              isol_n_q, isol_n_d;
  logic [NUM_IO-1:0] dir_q, dir_d;
  logic [NUM_IO-1:0] shadow_q, shadow_d;
  logic              done_q, done_d;
  logic              from_iso_q, from_iso_d;
  logic              abort;
  logic              cnt_zero;

  // Handshake: a request transfers on any edge where CFG_VALID and CFG_READY are both high;
  // CFG_DIR is sampled only then, and an unaccepted request must be held by the requester.
  assign abort     = FORCE_ISOLATE | ~FABRIC_READY;
  assign cnt_zero  = (cnt_q == '0);
  assign CFG_READY = (state_q == ST_ACTIVE) & ~FORCE_ISOLATE & FABRIC_READY;
  assign BUSY      = (state_q != ST_ACTIVE);
  assign CFG_DONE  = done_q;
  assign IO_ISOL_N = isol_n_q;
  assign DIR_MASK  = dir_q;
  assign DBG_STATE = state_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    isol_n_d   = isol_n_q;
    dir_d      = dir_q;
    shadow_d   = shadow_q;
    done_d     = 1'b0;
    from_iso_d = from_iso_q;
    if (state_q != ST_WAIT_FABRIC && abort) begin
      // Abort wins over acceptance and counter expiry; any pending shadow is dropped.
      state_d  = ST_WAIT_FABRIC;
      isol_n_d = 1'b0;
      dir_d    = '0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        ST_WAIT_FABRIC: begin
          if (!abort) begin
            state_d    = ST_SETTLE;
            cnt_d      = SETTLE_LD;
            from_iso_d = 1'b0;
          end
        end
        ST_SETTLE: begin
          if (cnt_zero) begin
            state_d  = ST_ACTIVE;
            isol_n_d = 1'b1;
            done_d   = from_iso_q;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (CFG_VALID) begin
            shadow_d = CFG_DIR;
            if (CFG_DIR == dir_q) begin
              done_d = 1'b1;
            end else begin
              state_d  = ST_ISO_ENTER;
              isol_n_d = 1'b0;
              cnt_d    = ISO_LD;
            end
          end
        end
        ST_ISO_ENTER: begin
          if (cnt_zero) begin
            dir_d      = shadow_q;
            state_d    = ST_SETTLE;
            cnt_d      = SETTLE_LD;
            from_iso_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = ST_WAIT_FABRIC;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_WAIT_FABRIC;
      cnt_q      <= '0;
      isol_n_q   <= 1'b0;
      dir_q      <= '0;
      shadow_q   <= '0;
      done_q     <= 1'b0;
      from_iso_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      isol_n_q   <= isol_n_d;
      dir_q      <= dir_d;
      shadow_q   <= shadow_d;
      done_q     <= done_d;
      from_iso_q <= from_iso_d;
    end
  end

endmodule
